// File: rtl/branch_target_stage_pkg.sv
// branch_target_stage_pkg: shared constants, payload layout and offset helper for the branch-target pipeline
package branch_target_stage_pkg;

  localparam int IMM_W       = 24;
  localparam int PC_AHEAD    = 8;
  localparam int LINK_OFFSET = 4;
  localparam int BT_PC_W     = 32;
  localparam int BT_TAG_W    = 4;

  // In S1 the target field carries pc+PC_AHEAD; S2 replaces it with the final target.
  typedef struct packed {
    logic [BT_PC_W-1:0]  target;
    logic [BT_PC_W-1:0]  off;
    logic [BT_PC_W-1:0]  link_addr;
    logic                link;
    logic [BT_TAG_W-1:0] tag;
    logic                fault;
  } bt_payload_t;

  // Word offset: shift left by 2, then sign-extend from bit 25 up to the PC width.
  function automatic logic [BT_PC_W-1:0] sext_branch_off(input logic [IMM_W-1:0] imm);
    return {{(BT_PC_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_target_stage_bt_pipe_slot.sv
// bt_pipe_slot: one valid/payload pipeline register with advance, flush and synchronous active-low reset
module bt_pipe_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         adv,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Load on advance; payload only moves when a valid entry arrives so a drained slot keeps its old data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= in_valid;
      if (in_valid) data <= in_data;
    end
  end

endmodule

// File: rtl/branch_target_stage.sv
// branch_target_stage: two-stage ARM branch-target / BL link-address generator with valid/ready flow control
module branch_target_stage #(
  parameter int PC_W     = branch_target_stage_pkg::BT_PC_W,
  parameter int TAG_W    = branch_target_stage_pkg::BT_TAG_W,
  parameter int PC_AHEAD = branch_target_stage_pkg::PC_AHEAD
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [23:0]      in_imm24,
  input  logic             in_link,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_target,
  output logic [PC_W-1:0]  out_link_addr,
  output logic             out_link,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_fault,
  output logic [1:0]       occupancy
);
  import branch_target_stage_pkg::*;

  bt_payload_t s1_in, s1_q, s2_in, s2_q;
  logic s1_valid, s2_valid, s1_adv, s2_adv;

  // Flow control plus per-stage payload formation: S1 does the cheap adds, S2 the full-width target add.
  always_comb begin
    s2_adv          = !s2_valid || out_ready;
    s1_adv          = !s1_valid || s2_adv;
    in_ready        = s1_adv && !flush;
    s1_in.target    = in_pc + PC_W'(PC_AHEAD);
    s1_in.off       = sext_branch_off(in_imm24);
    s1_in.link_addr = in_pc + PC_W'(LINK_OFFSET);
    s1_in.link      = in_link;
    s1_in.tag       = in_tag;
    s1_in.fault     = |in_pc[1:0];
    s2_in           = s1_q;
    s2_in.target    = s1_q.target + s1_q.off;
  end

  bt_pipe_slot #(.W($bits(bt_payload_t))) u_s1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .adv      (s1_adv),
    .in_valid (in_valid),
    .in_data  (s1_in),
    .valid    (s1_valid),
    .data     (s1_q)
  );

  bt_pipe_slot #(.W($bits(bt_payload_t))) u_s2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .adv      (s2_adv),
    .in_valid (s1_valid),
    .in_data  (s2_in),
    .valid    (s2_valid),
    .data     (s2_q)
  );

  assign out_valid     = s2_valid;
  assign out_target    = s2_q.target;
  assign out_link_addr = s2_q.link_addr;
  assign out_link      = s2_q.link;
  assign out_tag       = s2_q.tag;
  assign out_fault     = s2_q.fault;
  assign occupancy     = 2'(s1_valid) + 2'(s2_valid);

endmodule
